tli4970_frame_decoder: RTL
==========================

Name: tli4970_frame_decoder

Overview:
- Downstream consumer of the TLI4970 SPI control block. It takes each raw 16-bit word read from the current sensor, checks its parity and classifies it as either a sensor-value frame or a status frame.
- Valid sensor values are converted to a signed, offset-free current and filtered by a sliding-window moving average.
- A watchdog flags a stale sensor when no frames arrive; error/status counters feed diagnostics registers.

Parameters:
- AVG_LOG2, 3, log2 of moving-average window length (window = 2^AVG_LOG2 samples, 1..6)
- OFFSET, 4096, zero-current code subtracted from the 13-bit raw value
- TIMEOUT_CYCLES, 50000, clock cycles without an accepted sensor frame before stale asserts

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- frame_valid  input  1  single-cycle strobe: frame_data holds a newly received word
- frame_data  input  16  raw TLI4970 word
- current_raw  output  16  signed current code = raw[12:0] - OFFSET
- current_valid  output  1  1-cycle pulse when current_raw updates
- current_avg  output  16  signed moving average of the last 2^AVG_LOG2 accepted samples
- avg_valid  output  1  1-cycle pulse when current_avg updates (window full only)
- ocd_flag  output  1  bit13 of the last accepted sensor frame (over-current detect)
- status_word  output  16  last accepted status frame
- status_count  output  16  number of accepted status frames, saturating
- parity_error_count  output  16  number of frames dropped for parity, saturating
- stale  output  1  watchdog timeout flag

Behaviour:
- Frame format:
  - bit15 = 0: sensor frame; bit15 = 1: status frame.
  - bit14 = parity; a frame is valid when XOR of bits 15:0 = 0 (even ones count).
  - bit13 = OCD; bits 12:0 = unsigned current code.
- Pipeline:
  - Stage 1 registers frame_data and the parity result on frame_valid.
  - Stage 2 classifies and updates outputs.
  - current_valid pulses exactly 2 cycles after frame_valid.
  - avg_valid/current_avg update 1 cycle after current_valid.
  - frame_valid is accepted every cycle (back-to-back); no frame is dropped by the pipeline.
- Parity failure: frame discarded; parity_error_count += 1 (saturates at 0xFFFF); no other output changes.
- Sensor frame:
  - current_raw = zero-extended raw[12:0] minus OFFSET, 16-bit signed (range -4096..4095 at default).
  - ocd_flag = bit13; current_valid pulse; sample pushed into the averager.
- Status frame: status_word = frame_data; status_count += 1 (saturating); current/avg outputs unchanged.
- Averager:
  - Ring buffer of 2^AVG_LOG2 16-bit samples plus running sum of width 16+AVG_LOG2; write pointer wraps modulo window.
  - Per push: sum <= sum + new - oldest.
  - current_avg = sum arithmetic-shifted right by AVG_LOG2 (rounds toward -inf).
  - Fill counter saturates at window size; avg_valid stays low until the window is full, then pulses on every push.
- Watchdog:
  - Cycle counter cleared on every accepted sensor frame, otherwise increments (saturates).
  - stale <= 1 when counter reaches TIMEOUT_CYCLES.
  - stale clears on the cycle the next accepted sensor frame reaches stage 2.
  - Status and parity-error frames do not feed the watchdog.
- Reset (any time, including mid-pipeline):
  - All outputs, ring buffer, sum, fill counter, pointer, counters and watchdog are cleared to 0.
  - stale = 0; in-flight frames are discarded.
- A frame_valid coincident with reset is ignored.

Optional Feature:
- Macro TLI4970_PARITY_CHECK_EN.
- Defined: parity checked as above; failing frames dropped and counted.
- Undefined: parity ignored; every frame is classified by bit15 alone; parity_error_count held at 0.

Test Plan:
- Reset, then frame 0x5000 -> current_raw=0, ocd_flag=0, current_valid pulse 2 cycles after strobe; parity_error_count=0.
- Frame 0x1064 -> current_raw=100. Frame 0x0F9C -> current_raw=-100 (0xFF9C). Frame 0x3000 -> current_raw=0, ocd_flag=1.
- With TLI4970_PARITY_CHECK_EN: frame 0x1000 -> no current_valid, parity_error_count=1. Without the macro: same frame -> current_raw=0, count stays 0.
- AVG_LOG2=2:
  - Four back-to-back 0x1064 strobes -> avg_valid first pulses after the 4th, current_avg=100.
  - Then 0x5000 -> current_avg=75.
  - Then four 0x0F9C -> current_avg=-100.
- Frame 0xC003 -> status_word=0xC003, status_count=1, current_raw unchanged, no current_valid.
- TIMEOUT_CYCLES=100, no strobes -> stale=1 at cycle 100.
  - 0xC003 -> stale stays 1.
  - 0x5000 -> stale=0.
  - Assert reset mid-pipeline -> all outputs 0, no current_valid emitted.

Source files
------------

// File: rtl/tli4970_frame_decoder.sv
// TLI4970 word decoder: parity/classify, offset-free current, moving average, watchdog (parity check under TLI4970_PARITY_CHECK_EN).
// Latency: current 2 cycles after frame_valid, average 3 cycles; accepts a frame every cycle, no backpressure.
module tli4970_frame_decoder #(
  parameter int AVG_LOG2       = 3,
  parameter int OFFSET         = 4096,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_valid,
  input  logic [15:0] frame_data,
  output logic [15:0] current_raw,
  output logic        current_valid,
  output logic [15:0] current_avg,
  output logic        avg_valid,
  output logic        ocd_flag,
  output logic [15:0] status_word,
  output logic [15:0] status_count,
  output logic [15:0] parity_error_count,
  output logic        stale
);

  localparam int WIN  = 1 << AVG_LOG2;
  localparam int SUMW = 16 + AVG_LOG2;
  localparam int WDW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AVG_LOG2:0] WIN_FULL = (AVG_LOG2+1)'(WIN);
  localparam logic [WDW-1:0]    WD_MAX   = WDW'(TIMEOUT_CYCLES);

  logic        s1_vld;
  logic [15:0] s1_dat;
  logic        par_ok;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= frame_valid;
      if (frame_valid) s1_dat <= frame_data;
    end
  end

`ifdef TLI4970_PARITY_CHECK_EN
  logic s1_par_ok;

  // Even ones count over all 16 bits marks a good word.
  always_ff @(posedge clock) begin
    if (reset)            s1_par_ok <= 1'b0;
    else if (frame_valid) s1_par_ok <= ~^frame_data;
  end

  assign par_ok = s1_par_ok;
`else
  assign par_ok = 1'b1;
`endif

  logic        sensor_acc;
  logic        status_acc;
  logic        par_err;
  logic [15:0] raw_ext;
  logic [15:0] cur_next;

  assign sensor_acc = s1_vld & par_ok & ~s1_dat[15];
  assign status_acc = s1_vld & par_ok &  s1_dat[15];
  assign par_err    = s1_vld & ~par_ok;
  assign raw_ext    = {3'b000, s1_dat[12:0]};
  assign cur_next   = raw_ext - 16'(OFFSET);

  always_ff @(posedge clock) begin
    if (reset) begin
      current_valid      <= 1'b0;
      current_raw        <= '0;
      ocd_flag           <= 1'b0;
      status_word        <= '0;
      status_count       <= '0;
      parity_error_count <= '0;
    end else begin
      current_valid <= sensor_acc;
      if (sensor_acc) begin
        current_raw <= cur_next;
        ocd_flag    <= s1_dat[13];
      end
      if (status_acc) begin
        status_word <= s1_dat;
        if (status_count != 16'hFFFF) status_count <= status_count + 16'd1;
      end
      if (par_err && parity_error_count != 16'hFFFF)
        parity_error_count <= parity_error_count + 16'd1;
    end
  end

  logic [15:0]         ring [WIN];
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [AVG_LOG2:0]   fill;
  logic [SUMW-1:0]     sum;
  logic [SUMW-1:0]     sum_next;

  // Oldest sample is the slot about to be overwritten; slots start at zero so partial windows still sum correctly.
  assign sum_next = sum + {{AVG_LOG2{current_raw[15]}}, current_raw}
                        - {{AVG_LOG2{ring[wr_ptr][15]}}, ring[wr_ptr]};

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < WIN; i++) ring[i] <= '0;
      wr_ptr      <= '0;
      fill        <= '0;
      sum         <= '0;
      current_avg <= '0;
      avg_valid   <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (current_valid) begin
        ring[wr_ptr] <= current_raw;
        wr_ptr       <= wr_ptr + 1'b1;
        sum          <= sum_next;
        // Upper 16 bits of the sum are the floor-divided average.
        current_avg  <= sum_next[SUMW-1:AVG_LOG2];
        if (fill != WIN_FULL) fill <= fill + 1'b1;
        avg_valid    <= (fill >= WIN_FULL - 1'b1);
      end
    end
  end

  logic [WDW-1:0] wd_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt <= '0;
      stale  <= 1'b0;
    end else if (sensor_acc) begin
      wd_cnt <= '0;
      stale  <= 1'b0;
    end else begin
      if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt >= WD_MAX - 1'b1) stale <= 1'b1;
    end
  end

endmodule
